// File: rtl/layer7_weight_seq_ctrl_pkg.sv
// Shared types and sizing for the layer-7 weight memory sequencer.
// The word/row terminal counts are derived here so every file agrees on them.
package layer7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    READ  = 2'd3
  } w7_state_t;

  localparam int W7_WORDS_PER_ROW = 8;
  localparam int W7_ROWS_PER_BANK = 25;
  localparam int W7_NUM_WEIGHTS   = 2 * W7_ROWS_PER_BANK * W7_WORDS_PER_ROW;

  localparam int W7_WORD_CNT_W = 9;
  localparam int W7_ROW_CNT_W  = 5;

  localparam logic [W7_WORD_CNT_W-1:0] W7_LAST_WORD = W7_WORD_CNT_W'(W7_NUM_WEIGHTS - 1);
  localparam logic [W7_ROW_CNT_W-1:0]  W7_LAST_ROW  = W7_ROW_CNT_W'(W7_ROWS_PER_BANK - 1);

endpackage

// File: rtl/layer7_weight_seq_ctrl_if.sv
// Handshake and memory-port bundle for the layer-7 weight sequencer.
// master = bus/compute side driving requests, slave = the sequencer itself.
interface layer7_weight_seq_ctrl_if;
  logic        load_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        write_weight_signal;
  logic [15:0] write_weight_data;
  logic [15:0] write_weight_addr;
  logic        load_done;
  logic        rd_start;
  logic        rd_stall;
  logic        read_weight_signal;
  logic [15:0] read_weight_addr1;
  logic [15:0] read_weight_addr2;
  logic        rd_row_valid;
  logic [4:0]  rd_row_idx;
  logic        sweep_done;
  logic        busy;
  logic        err;

  modport master (
    output load_start, in_valid, in_data, rd_start, rd_stall,
    input  in_ready, write_weight_signal, write_weight_data, write_weight_addr,
           load_done, read_weight_signal, read_weight_addr1, read_weight_addr2,
           rd_row_valid, rd_row_idx, sweep_done, busy, err
  );

  modport slave (
    input  load_start, in_valid, in_data, rd_start, rd_stall,
    output in_ready, write_weight_signal, write_weight_data, write_weight_addr,
           load_done, read_weight_signal, read_weight_addr1, read_weight_addr2,
           rd_row_valid, rd_row_idx, sweep_done, busy, err
  );
endinterface

// File: rtl/layer7_weight_seq_ctrl_counter_cnn.sv
// Up-counter with synchronous clear and hold; used for the word and row indices.
module counter_cnn #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             keep,
  output logic [WIDTH-1:0] count
);

  // count register: clear beats keep, otherwise step by one
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!keep) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/layer7_weight_seq_ctrl.sv
// Layer-7 weight sequencer: streams 400 words into the weight memory, then
// serves paced dual-bank read sweeps of 25 rows each.
module layer7_weight_seq_ctrl
  import layer7_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  layer7_weight_seq_ctrl_if.slave  bus
);

  w7_state_t                 state_r;
  w7_state_t                 state_s;
  logic                      err_set_s;
  logic                      err_r;
  logic                      accept_s;
  logic                      issue_s;
  logic                      last_word_s;
  logic                      last_row_s;
  logic                      word_clear_s;
  logic                      word_keep_s;
  logic                      row_clear_s;
  logic                      row_keep_s;
  logic [W7_WORD_CNT_W-1:0]  word_cnt_r;
  logic [W7_ROW_CNT_W-1:0]   row_r;
  logic                      row_vld_r;
  logic [W7_ROW_CNT_W-1:0]   row_idx_r;
  logic                      sweep_done_r;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state and protocol-violation detection
  always_comb begin
    state_s   = state_r;
    err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        err_set_s = bus.rd_start;
        if (bus.load_start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        err_set_s = bus.load_start | bus.rd_start;
        if (accept_s && last_word_s) begin
          state_s = READY;
        end else begin
          state_s = LOAD;
        end
      end
      READY: begin
        // a simultaneous request pair reloads and flags the dropped sweep
        if (bus.load_start) begin
          state_s   = LOAD;
          err_set_s = bus.rd_start;
        end else if (bus.rd_start) begin
          state_s = READ;
        end else begin
          state_s = READY;
        end
      end
      READ: begin
        err_set_s = bus.load_start | bus.rd_start;
        if (issue_s && last_row_s) begin
          state_s = READY;
        end else begin
          state_s = READ;
        end
      end
      default: begin
        state_s   = IDLE;
        err_set_s = 1'b0;
      end
    endcase
  end

  assign accept_s    = (state_r == LOAD) && bus.in_valid;
  assign issue_s     = (state_r == READ) && !bus.rd_stall;
  assign last_word_s = (word_cnt_r == W7_LAST_WORD);
  assign last_row_s  = (row_r == W7_LAST_ROW);

  // counters self-clear outside their phase so every phase starts at zero
  assign word_clear_s = (state_r != LOAD) || (accept_s && last_word_s);
  assign word_keep_s  = !accept_s;
  assign row_clear_s  = (state_r != READ) || (issue_s && last_row_s);
  assign row_keep_s   = bus.rd_stall;

  counter_cnn #(.WIDTH(W7_WORD_CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (word_clear_s),
    .keep  (word_keep_s),
    .count (word_cnt_r)
  );

  counter_cnn #(.WIDTH(W7_ROW_CNT_W)) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (row_clear_s),
    .keep  (row_keep_s),
    .count (row_r)
  );

  // one-cycle read tracking matches the falling-edge memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      row_vld_r    <= 1'b0;
      row_idx_r    <= '0;
      sweep_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      row_vld_r    <= issue_s;
      row_idx_r    <= issue_s ? row_r : '0;
      sweep_done_r <= issue_s && last_row_s;
      err_r        <= err_r | err_set_s;
    end
  end

  assign bus.in_ready            = (state_r == LOAD);
  assign bus.write_weight_signal = accept_s;
  assign bus.write_weight_data   = accept_s ? bus.in_data : 16'h0000;
  assign bus.write_weight_addr   = accept_s ? {7'b0000000, word_cnt_r} : 16'h0000;
  assign bus.load_done           = (state_r == READY);

  assign bus.read_weight_signal  = (state_r == READ);
  assign bus.read_weight_addr1   = (state_r == READ) ? {11'b00000000000, row_r} : 16'h0000;
  assign bus.read_weight_addr2   = (state_r == READ) ? {11'b00000000000, row_r} : 16'h0000;
  assign bus.rd_row_valid        = row_vld_r;
  assign bus.rd_row_idx          = row_idx_r;
  assign bus.sweep_done          = sweep_done_r;
  assign bus.busy                = (state_r == LOAD) || (state_r == READ);
  assign bus.err                 = err_r;

endmodule

// File: tb/tb_layer7_weight_seq_ctrl.sv
// Directed bench for layer7_weight_seq_ctrl with a lane-packing weight memory model.
module tb_layer7_weight_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer7_weight_seq_ctrl_if bus_if ();

  layer7_weight_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int img_base = 0;
  int strobe_cnt = 0;

  logic [15:0] mem  [0:49][0:7];
  logic [15:0] rd_a [0:7];
  logic [15:0] rd_b [0:7];
  int wlane = 0;
  int wrow  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory write side: own lane/row counters, shared reset
  always @(posedge clk) begin
    if (rst) begin
      wlane <= 0;
      wrow  <= 0;
      strobe_cnt <= 0;
    end else if (bus_if.write_weight_signal) begin
      mem[wrow][wlane] <= bus_if.write_weight_data;
      strobe_cnt <= strobe_cnt + 1;
      if (wlane == 7) begin
        wlane <= 0;
        wrow  <= (wrow == 49) ? 0 : wrow + 1;
      end else begin
        wlane <= wlane + 1;
      end
    end
  end

  // memory read side, falling-edge clocked
  always @(negedge clk) begin
    if (bus_if.read_weight_signal && bus_if.read_weight_addr1 < 16'd25) begin
      for (int l = 0; l < 8; l++) begin
        rd_a[l] <= mem[bus_if.read_weight_addr1][l];
        rd_b[l] <= mem[bus_if.read_weight_addr2 + 16'd25][l];
      end
    end
  end

  task automatic check_image(input string tag, input int base, input int r_lo, input int r_hi);
    int errs = 0;
    for (int r = r_lo; r <= r_hi; r++)
      for (int l = 0; l < 8; l++)
        if (mem[r][l] !== 16'(base + 8*r + l)) errs++;
    check_val(tag, 64'(errs), 64'd0);
  endtask

  task automatic do_load(input int base, input bit gap, input int inject_at,
                         input int abort_at, output int cycles);
    int idx = 0;
    int cyc = 0;
    int s0;
    bit injected = 1'b0;
    @(posedge clk); #1 bus_if.load_start = 1'b1;
    @(posedge clk); #1 bus_if.load_start = 1'b0;
    check_val("ld_in_ready", 64'(bus_if.in_ready), 64'd1);
    check_val("ld_done_low", 64'(bus_if.load_done), 64'd0);
    s0 = strobe_cnt;
    while (idx < 400 && cyc < 2000) begin
      bus_if.in_valid = gap ? (cyc % 2 == 1) : 1'b1;
      bus_if.in_data  = 16'(base + idx);
      if (idx == inject_at && bus_if.in_valid && !injected) begin
        bus_if.load_start = 1'b1;
        bus_if.rd_start   = 1'b1;
        injected = 1'b1;
      end
      if (idx == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_in_ready", 64'(bus_if.in_ready), 64'd0);
        check_val("abort_wr", {31'd0, bus_if.write_weight_signal, bus_if.write_weight_addr,
                  bus_if.write_weight_data}, 64'd0);
        check_val("abort_flags", {60'd0, bus_if.load_done, bus_if.busy, bus_if.err,
                  bus_if.read_weight_signal}, 64'd0);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 16'h0000;
        cycles = cyc;
        return;
      end
      #1;
      if (bus_if.in_valid) begin
        check_val("wr_en",   64'(bus_if.write_weight_signal), 64'd1);
        check_val("wr_addr", 64'(bus_if.write_weight_addr), 64'(idx));
        check_val("wr_data", 64'(bus_if.write_weight_data), 64'(16'(base + idx)));
      end else begin
        check_val("wr_gap", {31'd0, bus_if.write_weight_signal, bus_if.write_weight_addr,
                  bus_if.write_weight_data}, 64'd0);
      end
      @(posedge clk); #1;
      bus_if.load_start = 1'b0;
      bus_if.rd_start   = 1'b0;
      if (bus_if.in_valid) idx++;
      cyc++;
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 16'h0000;
    cycles = cyc;
    check_val("ld_done", 64'(bus_if.load_done), 64'd1);
    check_val("ld_busy_low", 64'(bus_if.busy), 64'd0);
    check_val("ld_strobes", 64'(strobe_cnt - s0), 64'd400);
  endtask

  task automatic do_sweep(input int stall_row, input int stall_len, output int cycles);
    int exp_row = 0;
    int nstall = 0;
    int nvalid = 0;
    int prev_row;
    int errs;
    bit prev_issue;
    int cyc;
    @(posedge clk); #1 bus_if.rd_start = 1'b1;
    @(posedge clk); #1 bus_if.rd_start = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      check_val("rd_en",    64'(bus_if.read_weight_signal), 64'd1);
      check_val("rd_addr1", 64'(bus_if.read_weight_addr1), 64'(exp_row));
      check_val("rd_addr2", 64'(bus_if.read_weight_addr2), 64'(exp_row));
      bus_if.rd_stall = (exp_row == stall_row) && (nstall < stall_len);
      prev_row   = exp_row;
      prev_issue = !bus_if.rd_stall;
      if (bus_if.rd_stall) nstall++;
      @(posedge clk); #1;
      check_val("row_valid",  64'(bus_if.rd_row_valid), 64'(prev_issue));
      check_val("sweep_done", 64'(bus_if.sweep_done), 64'(prev_issue && prev_row == 24));
      if (prev_issue) begin
        nvalid++;
        check_val("row_idx", 64'(bus_if.rd_row_idx), 64'(prev_row));
        errs = 0;
        for (int l = 0; l < 8; l++) begin
          if (rd_a[l] !== 16'(img_base + 8*prev_row + l)) errs++;
          if (rd_b[l] !== 16'(img_base + 200 + 8*prev_row + l)) errs++;
        end
        check_val("row_data", 64'(errs), 64'd0);
        if (prev_row == 24) break;
        exp_row++;
      end
    end
    bus_if.rd_stall = 1'b0;
    cycles = cyc + 1;
    check_val("sweep_valids", 64'(nvalid), 64'd25);
    check_val("sweep_ready",  64'(bus_if.load_done), 64'd1);
    check_val("sweep_rd_off", {47'd0, bus_if.read_weight_signal, bus_if.read_weight_addr1}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    bus_if.load_start = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_data    = 16'h0000;
    bus_if.rd_start   = 1'b0;
    bus_if.rd_stall   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check_val("rst_flags", {58'd0, bus_if.in_ready, bus_if.load_done, bus_if.busy, bus_if.err,
              bus_if.rd_row_valid, bus_if.sweep_done}, 64'd0);
    check_val("rst_wr", {31'd0, bus_if.write_weight_signal, bus_if.write_weight_addr,
              bus_if.write_weight_data}, 64'd0);
    check_val("rst_rd", {27'd0, bus_if.read_weight_signal, bus_if.read_weight_addr1,
              bus_if.read_weight_addr2, bus_if.rd_row_idx}, 64'd0);

    // 1: back-to-back load
    img_base = 0;
    do_load(0, 1'b0, -1, -1, cycles);
    check_val("t1_cycles", 64'(cycles), 64'd400);
    check_val("t1_mem_49_7", 64'(mem[49][7]), 64'd399);
    check_image("t1_image", 0, 0, 49);

    // 3: unstalled sweep
    do_sweep(-1, 0, cycles);
    check_val("t3_cycles", 64'(cycles), 64'd25);

    // 4: three stall cycles at row 10
    do_sweep(10, 3, cycles);
    check_val("t4_cycles", 64'(cycles), 64'd28);

    // 2: gapped reload from READY
    do_load(0, 1'b1, -1, -1, cycles);
    check_val("t2_cycles", 64'(cycles), 64'd800);
    check_image("t2_image", 0, 0, 49);
    check_val("t2_err_clean", 64'(bus_if.err), 64'd0);

    // 5: protocol violations
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus_if.rd_start = 1'b1;
    @(posedge clk); #1 bus_if.rd_start = 1'b0;
    check_val("t5_err_idle", 64'(bus_if.err), 64'd1);
    check_val("t5_idle_held", {62'd0, bus_if.busy, bus_if.load_done}, 64'd0);
    img_base = 4096;
    do_load(4096, 1'b0, 100, -1, cycles);
    check_val("t5_cycles", 64'(cycles), 64'd400);
    check_val("t5_err_sticky", 64'(bus_if.err), 64'd1);
    check_image("t5_image", 4096, 0, 49);

    // 6: reset at word 123, then full reload
    do_load(8192, 1'b0, -1, 123, cycles);
    check_val("t6_abort_at", 64'(cycles), 64'd123);
    img_base = 12288;
    do_load(12288, 1'b0, -1, -1, cycles);
    check_image("t6_row0", 12288, 0, 0);
    check_image("t6_row49", 12288, 49, 49);
    do_sweep(-1, 0, cycles);
    check_val("t6_err_clear", 64'(bus_if.err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
